// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, field-format enum and the field-set payload
// used by the instruction encoder and the decode/ALU-select logic.
package riscv_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_LOAD  = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_JAL   = 3'd5,
    FMT_LUI   = 3'd6,
    FMT_AUIPC = 3'd7
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm;
  } instr_fields_t;

  // True when v is representable as a signed value of the given bit width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (bits - 1));
    return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/encoder_fifo.sv
// DEPTH x 32 synchronous FIFO buffering encoded words ahead of the IMEM write port.
module encoder_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WORD_W-1:0]         wdata,
  input  logic                      pop,
  output logic [WORD_W-1:0]         rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs RV32I instruction fields into machine words and streams them into IMEM
// through a small FIFO; session control via Start/Finish with a Done pulse.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              Finish,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        Fmt,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Rs1,
  input  logic [4:0]        Rs2,
  input  logic [2:0]        Funct3,
  input  logic              Alt,
  input  logic [31:0]       Imm,
  output logic              ImemWEn,
  input  logic              ImemReady,
  output logic [ADDR_W-1:0] ImemAddr,
  output logic [31:0]       ImemWData,
  output logic              Done,
  output logic              Err,
  output logic [7:0]        ErrCnt,
  output logic [ADDR_W-2:0] WordCnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic              start_ok_c;
  instr_fields_t     fld_c;
  logic [31:0]       word_c;
  logic              reject_c;
  logic              xfer_c;
  logic              pop_c;
  logic [31:0]       fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-2:0] word_cnt_q;
  logic              err_q;
  logic [7:0]        err_cnt_q;

  assign fld_c = '{fmt: fmt_e'(Fmt), rd: Rd, rs1: Rs1, rs2: Rs2,
                   funct3: Funct3, alt: Alt, imm: Imm};

  // Field packing and immediate range checks.
  always_comb begin
    word_c   = '0;
    reject_c = 1'b0;
    case (fld_c.fmt)
      FMT_R: begin
        word_c = {(fld_c.alt ? F7_ALT : F7_BASE), fld_c.rs2, fld_c.rs1,
                  fld_c.funct3, fld_c.rd, OPC_OP};
      end
      FMT_I: begin
        if ((fld_c.funct3 == F3_SLL) || (fld_c.funct3 == F3_SR)) begin
          word_c   = {(fld_c.alt ? F7_ALT : F7_BASE), fld_c.imm[4:0], fld_c.rs1,
                      fld_c.funct3, fld_c.rd, OPC_OP_IMM};
          reject_c = |fld_c.imm[31:5];
        end else begin
          word_c   = {fld_c.imm[11:0], fld_c.rs1, fld_c.funct3, fld_c.rd, OPC_OP_IMM};
          reject_c = !fits_signed(fld_c.imm, 12);
        end
      end
      FMT_LOAD: begin
        word_c   = {fld_c.imm[11:0], fld_c.rs1, fld_c.funct3, fld_c.rd, OPC_LOAD};
        reject_c = !fits_signed(fld_c.imm, 12);
      end
      FMT_S: begin
        word_c   = {fld_c.imm[11:5], fld_c.rs2, fld_c.rs1, fld_c.funct3,
                    fld_c.imm[4:0], OPC_STORE};
        reject_c = !fits_signed(fld_c.imm, 12);
      end
      FMT_B: begin
        word_c   = {fld_c.imm[12], fld_c.imm[10:5], fld_c.rs2, fld_c.rs1, fld_c.funct3,
                    fld_c.imm[4:1], fld_c.imm[11], OPC_BRANCH};
        reject_c = fld_c.imm[0] || !fits_signed(fld_c.imm, 13);
      end
      FMT_JAL: begin
        word_c   = {fld_c.imm[20], fld_c.imm[10:1], fld_c.imm[11], fld_c.imm[19:12],
                    fld_c.rd, OPC_JAL};
        reject_c = fld_c.imm[0] || !fits_signed(fld_c.imm, 21);
      end
      FMT_LUI: begin
        word_c   = {fld_c.imm[31:12], fld_c.rd, OPC_LUI};
        reject_c = |fld_c.imm[11:0];
      end
      FMT_AUIPC: begin
        word_c   = {fld_c.imm[31:12], fld_c.rd, OPC_AUIPC};
        reject_c = |fld_c.imm[11:0];
      end
      default: begin
        word_c   = '0;
        reject_c = 1'b0;
      end
    endcase
  end

  assign InReady = (state_q == S_RUN) && !fifo_full;
  assign xfer_c  = InValid && InReady;
  assign pop_c   = !fifo_empty && ImemReady;

  encoder_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (xfer_c && !reject_c),
    .wdata (word_c),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Session sequencing; Start takes priority over a same-cycle Finish in IDLE.
  always_comb begin
    state_d    = state_q;
    start_ok_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d    = S_RUN;
          start_ok_c = 1'b1;
        end
      end
      S_RUN:   if (Finish) state_d = S_FLUSH;
      S_FLUSH: if (fifo_count == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= ADDR_W'(BASE_ADDR);
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else if (start_ok_c) begin
      addr_q     <= ADDR_W'(BASE_ADDR);
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (pop_c) begin
        addr_q     <= addr_q + ADDR_W'(4);
        word_cnt_q <= word_cnt_q + (ADDR_W-1)'(1);
      end
      if (xfer_c && reject_c) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign ImemWEn   = !fifo_empty;
  assign ImemWData = fifo_empty ? 32'h0 : fifo_rdata;
  assign ImemAddr  = addr_q;
  assign Done      = (state_q == S_DONE);
  assign Err       = err_q;
  assign ErrCnt    = err_cnt_q;
  assign WordCnt   = word_cnt_q;

endmodule
